// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [3:0]  op0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic [3:0]  op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_res;
  logic [3:0]  resp_flags;
  logic        busy;

  modport master (
    output req_valid, a0, b0, op0, a1, b1, op1, resp_ready,
    input  req_ready, resp_valid, resp_res, resp_flags, busy
  );

  modport slave (
    input  req_valid, a0, b0, op0, a1, b1, op1, resp_ready,
    output req_ready, resp_valid, resp_res, resp_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; operands latched on accept, result captured after EXEC_CYCLES.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

  state_e      state_q;
  logic        prio_q;
  logic        owner_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [1:0]  resp_valid_q;
  logic [31:0] resp_res_q;
  logic [3:0]  resp_flags_q;

  logic [1:0]  grant;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_ovf;
  logic [3:0]  alu_flags;

  // Grant is gated by rst_n so req_ready drops with the asynchronous reset.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state_q == StIdle) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // The ALU only ever sees the latched operands.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_q)
      4'd0: begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum[31:0];
        alu_carry = sum[32];
        alu_ovf   = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
      end
      4'd1: begin
        sum       = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        alu_res   = sum[31:0];
        alu_carry = sum[32];
        alu_ovf   = (a_q[31] != b_q[31]) && (sum[31] != a_q[31]);
      end
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = a_q << b_q[4:0];
      4'd6:    alu_res = a_q >> b_q[4:0];
      4'd7:    alu_res = $unsigned($signed(a_q) >>> b_q[4:0]);
      4'd8:    alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      4'd9:    alu_res = {31'd0, a_q < b_q};
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[31], alu_res == 32'd0, alu_carry, alu_ovf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      resp_valid_q <= 2'b00;
      resp_res_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant != 2'b00) begin
            owner_q <= grant[1];
            a_q     <= grant[1] ? bus.a1 : bus.a0;
            b_q     <= grant[1] ? bus.b1 : bus.b0;
            op_q    <= grant[1] ? bus.op1 : bus.op0;
            cnt_q   <= CntInit;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            resp_res_q   <= alu_res;
            resp_flags_q <= alu_flags;
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (bus.resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            prio_q       <= ~owner_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_res   = resp_res_q;
  assign bus.resp_flags = resp_flags_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: one DUT with EXEC_CYCLES=1 and one with 3, the idle
// one held in reset; expectations come from an arithmetic ALU model and a round-robin model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_res;
  logic [3:0]  resp_flags;
  logic        busy;
  logic        rst_n1, rst_n3;

  int n_checks = 0;
  int n_fail = 0;
  bit exp_prio = 1'b0;

  alu_arbiter_if if1();
  alu_arbiter_if if3();

  assign if1.req_valid = req_valid;  assign if3.req_valid = req_valid;
  assign if1.resp_ready = resp_ready; assign if3.resp_ready = resp_ready;
  assign if1.a0 = a0;   assign if3.a0 = a0;
  assign if1.b0 = b0;   assign if3.b0 = b0;
  assign if1.op0 = op0; assign if3.op0 = op0;
  assign if1.a1 = a1;   assign if3.a1 = a1;
  assign if1.b1 = b1;   assign if3.b1 = b1;
  assign if1.op1 = op1; assign if3.op1 = op1;

  assign rst_n1 = rst_n & ~sel;
  assign rst_n3 = rst_n & sel;

  alu_arbiter #(.EXEC_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1.slave));
  alu_arbiter #(.EXEC_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n3), .bus(if3.slave));

  assign req_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign resp_valid = sel ? if3.resp_valid : if1.resp_valid;
  assign resp_res   = sel ? if3.resp_res   : if1.resp_res;
  assign resp_flags = sel ? if3.resp_flags : if1.resp_flags;
  assign busy       = sel ? if3.busy       : if1.busy;

  // Returns {N,Z,C,V,res}; carry/overflow computed with wide integer arithmetic.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    logic c, v;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'd4294967295;
        s = sa + sb;
        v = s != longint'($signed(r));
      end
      4'd1: begin
        r = a - b;
        c = a >= b;
        s = sa - sb;
        v = s != longint'($signed(r));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  function automatic int exec_cycles();
    return sel ? 3 : 1;
  endfunction

  // Called on the negedge just after the accept edge; returns edges until resp_valid, -1 on timeout.
  task automatic wait_resp(output int m);
    m = 0;
    while (resp_valid === 2'b00 && m < 40) begin
      @(negedge clk);
      m++;
    end
    if (m >= 40) m = -1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0; req_valid = 2'b11; resp_ready = 2'b00;
    @(negedge clk); @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    n_checks++; if (resp_res !== 32'd0) begin n_fail++; $display("FAIL reset_resp_res: got %h want 0", resp_res); end
    n_checks++; if (resp_flags !== 4'd0) begin n_fail++; $display("FAIL reset_resp_flags: got %b want 0000", resp_flags); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    req_valid = 2'b00; rst_n = 1'b1; exp_prio = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ready %b busy %b want 00/0", req_ready, busy); end
  endtask

  task automatic test_single();
    int m;
    req_valid = 2'b01; a0 = 32'hffffffff; b0 = 32'd0; op0 = 4'd2; a1 = 32'h1234; op1 = 4'd0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_exec: busy %b valid %b want 1/00", busy, resp_valid); end
    wait_resp(m);
    n_checks++; if (m != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", m); end
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b want 01", resp_valid); end
    n_checks++; if (resp_res !== 32'd0) begin n_fail++; $display("FAIL single_res: got %h want 0", resp_res); end
    n_checks++; if (resp_flags !== 4'b0100) begin n_fail++; $display("FAIL single_flags: got %b want 0100", resp_flags); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_hold: busy %b valid %b want 1/01", busy, resp_valid); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    n_checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_done: busy %b valid %b want 0/00", busy, resp_valid); end
    exp_prio = 1'b1;
  endtask

  task automatic test_simultaneous();
    int m;
    bit own;
    logic [35:0] exp;
    apply_reset();
    a0 = 32'hffffffff; b0 = 32'h7fffffff; op0 = 4'd4;
    a1 = 32'h0000000f; b1 = 32'd4;         op1 = 4'd5;
    req_valid = 2'b11;
    for (int round = 0; round < 3; round++) begin
      own = exp_prio;
      exp = own ? alu_model(a1, b1, op1) : alu_model(a0, b0, op0);
      #1;
      n_checks++; if (req_ready !== (own ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL simul_grant%0d: got %b want %b", round, req_ready, own ? 2'b10 : 2'b01); end
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL simul_exec_ready%0d: got %b want 00", round, req_ready); end
      wait_resp(m);
      n_checks++; if (m != exec_cycles()) begin n_fail++; $display("FAIL simul_latency%0d: got %0d want %0d", round, m, exec_cycles()); end
      n_checks++; if (resp_valid !== (own ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL simul_owner%0d: got %b want %b", round, resp_valid, own ? 2'b10 : 2'b01); end
      n_checks++; if (resp_res !== exp[31:0] || resp_flags !== exp[35:32]) begin n_fail++; $display("FAIL simul_result%0d: got %h/%b want %h/%b", round, resp_res, resp_flags, exp[31:0], exp[35:32]); end
      resp_ready = 2'b11;
      @(negedge clk);
      resp_ready = 2'b00;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL simul_clear%0d: got %b want 00", round, resp_valid); end
      exp_prio = ~own;
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int m;
    req_valid = 2'b10; a1 = 32'd1; b1 = 32'd1; op1 = 4'd6;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b11; a0 = 32'd5; b0 = 32'd6; op0 = 4'd0;
    wait_resp(m);
    n_checks++; if (m != exec_cycles()) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", m, exec_cycles()); end
    resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 2'b10 || resp_res !== 32'd0 || resp_flags !== 4'b0100 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold%0d: valid %b res %h flags %b ready %b want 10/0/0100/00", i, resp_valid, resp_res, resp_flags, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
    exp_prio = 1'b0;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_clear: got %b want 00", resp_valid); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_next_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int m;
    logic [31:0] sa, sb;
    logic [3:0] sop;
    logic [35:0] exp;
    for (int i = 0; i < 3; i++) begin
      sa = $urandom; sb = $urandom_range(0, 40); sop = 4'($urandom_range(0, 9));
      a0 = sa; b0 = sb; op0 = sop; req_valid = 2'b01;
      exp = alu_model(sa, sb, sop);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL opchg_grant%0d: got %b want 01", i, req_ready); end
      @(negedge clk);
      req_valid = 2'b00; a0 = ~sa; b0 = sb + 32'd3; op0 = sop + 4'd1;
      wait_resp(m);
      n_checks++; if (m != exec_cycles() || resp_valid !== 2'b01) begin n_fail++; $display("FAIL opchg_resp%0d: lat %0d valid %b want %0d/01", i, m, resp_valid, exec_cycles()); end
      n_checks++; if (resp_res !== exp[31:0] || resp_flags !== exp[35:32]) begin n_fail++; $display("FAIL opchg_result%0d: got %h/%b want %h/%b", i, resp_res, resp_flags, exp[31:0], exp[35:32]); end
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;
      exp_prio = 1'b1;
    end
  endtask

  task automatic test_latency();
    int m;
    sel = 1'b1;
    exp_prio = 1'b0;
    @(negedge clk);
    req_valid = 2'b01; a0 = 32'd0; b0 = 32'h38; op0 = 4'd3;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL lat_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(m);
    n_checks++; if (m != 3) begin n_fail++; $display("FAIL lat_edges: got %0d want 3", m); end
    n_checks++; if (resp_valid !== 2'b01 || resp_res !== 32'h38 || resp_flags !== 4'b0000) begin
      n_fail++; $display("FAIL lat_result: valid %b res %h flags %b want 01/38/0000", resp_valid, resp_res, resp_flags);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    exp_prio = 1'b1;
  endtask

  task automatic test_reset_exec();
    int m;
    logic [35:0] exp;
    req_valid = 2'b10; a1 = 32'd7; b1 = 32'd9; op1 = 4'd0;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rstx_grant: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstx_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 2'b00 || busy !== 1'b0 || resp_res !== 32'd0 || resp_flags !== 4'd0) begin
      n_fail++; $display("FAIL rstx_async: valid %b busy %b res %h flags %b want 00/0/0/0000", resp_valid, busy, resp_res, resp_flags);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstx_no_resp%0d: valid %b busy %b want 00/0", i, resp_valid, busy); end
    end
    a0 = $urandom; b0 = $urandom; op0 = 4'd1; a1 = $urandom; b1 = $urandom; op1 = 4'd4;
    exp = alu_model(a0, b0, op0);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstx_grant_after: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(m);
    n_checks++; if (m != 3 || resp_valid !== 2'b01) begin n_fail++; $display("FAIL rstx_resp: lat %0d valid %b want 3/01", m, resp_valid); end
    n_checks++; if (resp_res !== exp[31:0] || resp_flags !== exp[35:32]) begin n_fail++; $display("FAIL rstx_result: got %h/%b want %h/%b", resp_res, resp_flags, exp[31:0], exp[35:32]); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    exp_prio = 1'b1;
  endtask

  task automatic test_random(input int n);
    int m, d;
    logic [1:0] rv, own_bit;
    bit own;
    logic [35:0] exp;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rv = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom; op1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) b0 = $urandom_range(0, 31);
      own = (rv == 2'b11) ? exp_prio : rv[1];
      own_bit = own ? 2'b10 : 2'b01;
      exp = own ? alu_model(a1, b1, op1) : alu_model(a0, b0, op0);
      req_valid = rv;
      #1;
      n_checks++; if (req_ready !== own_bit) begin n_fail++; $display("FAIL rand_grant%0d: got %b want %b", i, req_ready, own_bit); end
      @(negedge clk);
      req_valid = 2'($urandom_range(0, 3));
      a0 = $urandom; a1 = $urandom; op0 = op0 + 4'd3; op1 = op1 + 4'd5;
      wait_resp(m);
      n_checks++; if (m != exec_cycles() || resp_valid !== own_bit) begin
        n_fail++; $display("FAIL rand_resp%0d: lat %0d valid %b want %0d/%b", i, m, resp_valid, exec_cycles(), own_bit);
      end
      n_checks++; if (resp_res !== exp[31:0] || resp_flags !== exp[35:32]) begin
        n_fail++; $display("FAIL rand_result%0d: got %h/%b want %h/%b", i, resp_res, resp_flags, exp[31:0], exp[35:32]);
      end
      d = $urandom_range(0, 3);
      resp_ready = ~own_bit;
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        n_checks++; if (resp_valid !== own_bit || req_ready !== 2'b00) begin
          n_fail++; $display("FAIL rand_hold%0d: valid %b ready %b want %b/00", i, resp_valid, req_ready, own_bit);
        end
      end
      resp_ready = own_bit;
      @(negedge clk);
      resp_ready = 2'b00;
      req_valid = 2'b00;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rand_clear%0d: got %b want 00", i, resp_valid); end
      exp_prio = ~own;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_operand_change();
    test_latency();
    test_reset_exec();
    test_random(25);
    sel = 1'b0;
    exp_prio = 1'b0;
    @(negedge clk);
    test_random(25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
